// File: rtl/fifo_read_drainer_if.sv
// Downstream valid/ready stream carrying words drained from the FIFO.
//   data  : word at the head of the drainer's skid buffer
//   valid : data is meaningful and waiting to be taken
//   ready : consumer accepts data this cycle
// master = drainer side, slave = consumer side.
interface fifo_read_drainer_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/fifo_read_drainer.sv
// Read-side master for a synchronous FIFO. Issues rd_en, catches the word
// returned one cycle later into a small skid buffer and presents the buffer
// head on a valid/ready stream, sustaining one word per cycle. Tracks words
// delivered and latches FIFO underflow reports against our own reads.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   enable           allow new reads (an in-flight word is still captured)
//   fifo_empty       FIFO empty flag
//   fifo_underflow   FIFO underflow flag, valid the cycle after rd_en
//   fifo_data_out    FIFO read data, valid the cycle after rd_en
//   fifo_rd_en       read request to FIFO (combinational)
//   m                downstream stream (master modport)
//   rd_count         words delivered downstream, wrapping
//   err_underflow    sticky underflow error
//   err_clr          synchronous clear of err_underflow (a new error wins)
module fifo_read_drainer #(
  parameter int FIFO_WIDTH = 16,
  parameter int SKID_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  output logic                  fifo_rd_en,
  fifo_read_drainer_if.master   m,
  output logic [CNT_WIDTH-1:0]  rd_count,
  output logic                  err_underflow,
  input  logic                  err_clr
);
  localparam int PW = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  // One spare bit so occupancy + inflight never aliases below SKID_DEPTH.
  localparam int OW = PW + 2;

  logic [SKID_DEPTH-1:0][FIFO_WIDTH-1:0] skid;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [OW-1:0] occupancy;
  logic [OW-1:0] credit_use;
  logic          inflight;
  logic          valid;
  logic          push;
  logic          pop;

  assign valid   = (occupancy != '0);
  assign m.valid = valid;
  assign m.data  = skid[rd_ptr];
  assign pop     = valid & m.ready;
  // A returning word is only real if the FIFO did not flag it as underflow.
  assign push    = inflight & ~fifo_underflow;

  // Credit: slots already held or promised, net of the word leaving now.
  // Issuing only while this is below SKID_DEPTH means the returning word
  // always has a slot, so the skid can never overrun.
  assign credit_use = occupancy + OW'(inflight) - OW'(pop);
  assign fifo_rd_en = rst_n & enable & ~fifo_empty &
                      (credit_use < OW'(SKID_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid          <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      occupancy     <= '0;
      inflight      <= 1'b0;
      rd_count      <= '0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (push) begin
        skid[wr_ptr] <= fifo_data_out;
        wr_ptr       <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        rd_count <= rd_count + CNT_WIDTH'(1);
      end
      occupancy <= occupancy + OW'(push) - OW'(pop);
      // Set has priority over clear.
      if (inflight && fifo_underflow) err_underflow <= 1'b1;
      else if (err_clr)               err_underflow <= 1'b0;
    end
  end
endmodule

// File: tb/tb_fifo_read_drainer.sv
// Bench for fifo_read_drainer: a queue-based FIFO model feeds the DUT, every
// delivered word is collected, and each scenario compares the delivered
// sequence, handshake timing, counter and error flag against values derived
// from the FIFO contents written by the scenario.
module tb_fifo_read_drainer;
  localparam int W  = 16;
  localparam int D  = 2;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_rd_en;
  logic [CW-1:0] rd_count;
  logic          err_underflow;
  logic          err_clr = 1'b0;

  int tests = 0;
  int fails = 0;

  fifo_read_drainer_if #(.WIDTH(W)) s();

  fifo_read_drainer #(.FIFO_WIDTH(W), .SKID_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_data_out(fifo_data_out),
    .fifo_rd_en(fifo_rd_en), .m(s.master), .rd_count(rd_count),
    .err_underflow(err_underflow), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  // FIFO model: registered read data and underflow flag, count seen by the
  // DUT is updated at the clock edge.
  logic [W-1:0] fq[$];
  int           fcnt = 0;
  logic         wr_en = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         force_uf = 1'b0;
  int           rd_ok = 0;
  int           rd_ok_base = 0;
  int           maxocc = 0;
  logic [W-1:0] got_q[$];

  assign fifo_empty = (fcnt == 0);

  always @(posedge clk) begin
    if (fifo_rd_en && fq.size() > 0) begin
      fifo_data_out <= fq.pop_front();
      if (!force_uf) rd_ok++;
    end
    fifo_underflow <= fifo_rd_en & force_uf;
    if (wr_en) fq.push_back(wr_data);
    fcnt <= fq.size();
  end

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // record any word that the coming rising edge hands downstream.
  task automatic step(input logic en, input logic rdy, input logic wr,
                      input logic [W-1:0] wd, input logic uf, input logic clr,
                      output logic rd, output logic v, output logic [W-1:0] d);
    int occ;
    @(negedge clk);
    enable = en; s.ready = rdy; wr_en = wr; wr_data = wd;
    force_uf = uf; err_clr = clr;
    #1;
    rd = fifo_rd_en; v = s.valid; d = s.data;
    occ = (rd_ok - rd_ok_base) - got_q.size();
    if (occ > maxocc) maxocc = occ;
    if (s.valid && rdy) got_q.push_back(s.data);
  endtask

  task automatic do_reset(input logic flush);
    @(negedge clk);
    enable = 0; s.ready = 0; wr_en = 0; force_uf = 0; err_clr = 0;
    rst_n = 0;
    if (flush) fq.delete();
    repeat (2) @(negedge clk);
    rst_n = 1;
    got_q.delete();
    rd_ok_base = rd_ok;
    maxocc = 0;
  endtask

  task automatic preload(input logic [W-1:0] base, input int n);
    logic rd, v; logic [W-1:0] d;
    for (int i = 0; i < n; i++) step(0, 0, 1, base + W'(i), 0, 0, rd, v, d);
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst_n = 0; enable = 1; s.ready = 1;
    wr_en = 1; wr_data = 16'hBEEF;
    repeat (2) @(negedge clk);
    wr_en = 0;
    #1;
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b exp 0", fifo_rd_en); end
    tests++; if (s.valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", s.valid); end
    tests++; if (s.data !== '0) begin fails++; $display("FAIL reset_data: got %h exp 0", s.data); end
    tests++; if (rd_count !== '0) begin fails++; $display("FAIL reset_count: got %0d exp 0", rd_count); end
    tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL reset_err: got %b exp 0", err_underflow); end
    do_reset(1);
  endtask

  task automatic test_stream;
    logic rd, v; logic [W-1:0] d;
    do_reset(1);
    preload(16'h0001, 8);
    for (int i = 0; i < 12; i++) begin
      step(1, 1, 0, 0, 0, 0, rd, v, d);
      tests++; if (rd !== 1'(i < 8)) begin fails++; $display("FAIL stream_rd_en c%0d: got %b exp %b", i, rd, i < 8); end
      tests++; if (v !== 1'(i >= 2 && i < 10)) begin fails++; $display("FAIL stream_valid c%0d: got %b exp %b", i, v, (i >= 2 && i < 10)); end
    end
    step(0, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (got_q.size() != 8) begin fails++; $display("FAIL stream_count: got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got_q[i] !== W'(i + 1)) begin fails++; $display("FAIL stream_data %0d: got %h exp %h", i, got_q[i], i + 1); end
    end
    tests++; if (rd_count !== CW'(8)) begin fails++; $display("FAIL stream_rd_count: got %0d exp 8", rd_count); end
  endtask

  task automatic test_backpressure;
    logic rd, v; logic [W-1:0] d;
    int nrd;
    do_reset(1);
    preload(16'h0001, 8);
    nrd = 0;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 0, 0, 0, 0, rd, v, d);
      nrd += int'(rd);
      if (i >= 2) begin
        tests++; if (!(v === 1'b1 && d === 16'h0001)) begin fails++; $display("FAIL bp_hold c%0d: got v=%b d=%h exp v=1 d=0001", i, v, d); end
      end
    end
    tests++; if (nrd != D) begin fails++; $display("FAIL bp_reads: got %0d exp %0d", nrd, D); end
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (got_q.size() != 8) begin fails++; $display("FAIL bp_count: got %0d exp 8", got_q.size()); end
    for (int i = 0; i < 8; i++) begin
      tests++; if (got_q[i] !== W'(i + 1)) begin fails++; $display("FAIL bp_data %0d: got %h exp %h", i, got_q[i], i + 1); end
    end
  endtask

  task automatic test_random;
    logic rd, v; logic [W-1:0] d;
    logic [W-1:0] wl[$];
    logic wr; logic [W-1:0] wd;
    int cyc;
    do_reset(1);
    cyc = 0;
    while (got_q.size() < 1000 && cyc < 20000) begin
      wr = (wl.size() < 1000) && 1'($urandom_range(0, 1));
      wd = W'($urandom);
      if (wr) wl.push_back(wd);
      step(1, 1'($urandom_range(0, 1)), wr, wd, 0, 0, rd, v, d);
      cyc++;
    end
    step(1, 0, 0, 0, 0, 0, rd, v, d);
    tests++; if (got_q.size() != 1000) begin fails++; $display("FAIL rand_count: got %0d exp 1000 after %0d cycles", got_q.size(), cyc); end
    for (int i = 0; i < 1000 && i < got_q.size(); i++) begin
      tests++; if (got_q[i] !== wl[i]) begin fails++; $display("FAIL rand_data %0d: got %h exp %h", i, got_q[i], wl[i]); end
    end
    tests++; if (maxocc > D) begin fails++; $display("FAIL rand_occupancy: got %0d exp <= %0d", maxocc, D); end
    tests++; if (rd_count !== CW'(1000)) begin fails++; $display("FAIL rand_rd_count: got %0d exp %0d", rd_count, 1000 % 16); end
  endtask

  task automatic test_underflow;
    logic rd, v; logic [W-1:0] d;
    do_reset(1);
    preload(16'h0A01, 3);
    step(1, 1, 0, 0, 1, 0, rd, v, d);
    tests++; if (rd !== 1'b1) begin fails++; $display("FAIL uf_rd_en: got %b exp 1", rd); end
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (got_q.size() != 2) begin fails++; $display("FAIL uf_count: got %0d exp 2", got_q.size()); end
    tests++; if (got_q[0] !== 16'h0A02) begin fails++; $display("FAIL uf_data0: got %h exp 0a02", got_q[0]); end
    tests++; if (got_q[1] !== 16'h0A03) begin fails++; $display("FAIL uf_data1: got %h exp 0a03", got_q[1]); end
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0, 0, 0, rd, v, d);
      tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_sticky c%0d: got %b exp 1", i, err_underflow); end
    end
    step(0, 1, 0, 0, 0, 1, rd, v, d);
    step(0, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (err_underflow !== 1'b0) begin fails++; $display("FAIL uf_clear: got %b exp 0", err_underflow); end
    preload(16'h0A04, 1);
    step(1, 1, 0, 0, 1, 0, rd, v, d);
    step(1, 1, 0, 0, 0, 1, rd, v, d);
    step(0, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (err_underflow !== 1'b1) begin fails++; $display("FAIL uf_set_wins: got %b exp 1", err_underflow); end
    tests++; if (got_q.size() != 2) begin fails++; $display("FAIL uf_dropped: got %0d words exp 2", got_q.size()); end
  endtask

  task automatic test_mid_reset;
    logic rd, v; logic [W-1:0] d;
    logic [W-1:0] snap[$];
    do_reset(1);
    preload(16'h5001, 6);
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0, 0, rd, v, d);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 0, rd, v, d);
    tests++; if (rd_count !== CW'(1)) begin fails++; $display("FAIL mrst_pre_count: got %0d exp 1", rd_count); end
    rst_n = 0;
    #1;
    tests++; if (s.valid !== 1'b0) begin fails++; $display("FAIL mrst_valid: got %b exp 0", s.valid); end
    tests++; if (s.data !== '0) begin fails++; $display("FAIL mrst_data: got %h exp 0", s.data); end
    tests++; if (rd_count !== '0) begin fails++; $display("FAIL mrst_count: got %0d exp 0", rd_count); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL mrst_rd_en: got %b exp 0", fifo_rd_en); end
    snap = fq;
    repeat (2) @(negedge clk);
    rst_n = 1;
    got_q.delete();
    step(0, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (v !== 1'b0) begin fails++; $display("FAIL mrst_stale: got valid %b data %h exp valid 0", v, d); end
    for (int i = 0; i < 10; i++) step(1, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (got_q.size() != snap.size()) begin fails++; $display("FAIL mrst_drain_count: got %0d exp %0d", got_q.size(), snap.size()); end
    for (int i = 0; i < snap.size(); i++) begin
      tests++; if (got_q[i] !== snap[i]) begin fails++; $display("FAIL mrst_drain %0d: got %h exp %h", i, got_q[i], snap[i]); end
    end
  endtask

  task automatic test_enable_drop;
    logic rd, v; logic [W-1:0] d;
    do_reset(1);
    preload(16'h6001, 3);
    step(1, 1, 0, 0, 0, 0, rd, v, d);
    tests++; if (rd !== 1'b1) begin fails++; $display("FAIL en_first_rd: got %b exp 1", rd); end
    for (int i = 0; i < 6; i++) begin
      step(0, 1, 0, 0, 0, 0, rd, v, d);
      tests++; if (rd !== 1'b0) begin fails++; $display("FAIL en_no_rd c%0d: got %b exp 0", i, rd); end
    end
    tests++; if (got_q.size() != 1) begin fails++; $display("FAIL en_count: got %0d exp 1", got_q.size()); end
    tests++; if (got_q[0] !== 16'h6001) begin fails++; $display("FAIL en_data: got %h exp 6001", got_q[0]); end
    tests++; if (fq.size() != 2) begin fails++; $display("FAIL en_fifo_left: got %0d exp 2", fq.size()); end
  endtask

  task automatic test_count_wrap;
    logic rd, v; logic [W-1:0] d;
    logic saw15;
    do_reset(1);
    preload(16'h7000, 16);
    saw15 = 0;
    for (int i = 0; i < 22; i++) begin
      step(1, 1, 0, 0, 0, 0, rd, v, d);
      if (rd_count === CW'(15)) saw15 = 1;
    end
    tests++; if (got_q.size() != 16) begin fails++; $display("FAIL wrap_pops: got %0d exp 16", got_q.size()); end
    tests++; if (saw15 !== 1'b1) begin fails++; $display("FAIL wrap_saw15: got %b exp 1", saw15); end
    tests++; if (rd_count !== '0) begin fails++; $display("FAIL wrap_count: got %0d exp 0", rd_count); end
  endtask

  initial begin
    s.ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_random();
    test_underflow();
    test_mid_reset();
    test_enable_drop();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
